// File: rtl/echo_capture_channel_if.sv
// Bundle of the echo recorder's sample, control, status and readout signals.
// The master side feeds samples and requests words; the slave side is the recorder.
interface echo_capture_channel_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned TS_W   = 13,
  parameter int unsigned DLY_W  = 8
) ();
  logic [DATA_W-1:0] din;
  logic              start_pulse;
  logic              stop_pulse;
  logic              stop_recording;
  logic [DLY_W-1:0]  stop_delay;
  logic [TS_W-1:0]   abs_counter;
  logic              rd_req;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_last;
  logic              frame_ready;
  logic              busy;
  logic              echo_pulse_detected;
  logic              wrapped;
  logic [ADDR_W:0]   sample_length;
  logic [TS_W-1:0]   timestamp;

  modport master (
    output din, start_pulse, stop_pulse, stop_recording, stop_delay, abs_counter, rd_req,
    input  rd_data, rd_valid, rd_last, frame_ready, busy, echo_pulse_detected, wrapped,
           sample_length, timestamp
  );

  modport slave (
    input  din, start_pulse, stop_pulse, stop_recording, stop_delay, abs_counter, rd_req,
    output rd_data, rd_valid, rd_last, frame_ready, busy, echo_pulse_detected, wrapped,
           sample_length, timestamp
  );
endinterface

// File: rtl/echo_capture_channel.sv
// Single-channel echo recorder: ring-buffers samples from arm through a post-stop delay,
// then freezes the frame and reads it back oldest-first with one-cycle read latency.
module echo_capture_channel #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned TS_W   = 13,
  parameter int unsigned DLY_W  = 8
) (
  input logic                  i_clk,
  input logic                  i_reset,
  echo_capture_channel_if.slave bus
);

  localparam int unsigned Depth = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LenMax = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {StIdle, StArmed, StPost, StDone} state_e;

  state_e            r_state, w_state_d;
  logic [DATA_W-1:0] r_mem [Depth];
  logic [ADDR_W-1:0] r_wptr, w_wptr_d;
  logic [ADDR_W-1:0] r_rptr, w_rptr_d;
  logic [ADDR_W:0]   r_len, w_len_d;
  logic [ADDR_W:0]   r_rd_cnt, w_rd_cnt_d;
  logic [DLY_W-1:0]  r_dly, w_dly_d;
  logic              r_wrapped, w_wrapped_d;
  logic              r_echo, w_echo_d;
  logic [TS_W-1:0]   r_ts, w_ts_d;
  logic [DATA_W-1:0] r_rd_data, w_rd_data_d;
  logic              r_rd_valid, w_rd_valid_d;
  logic              r_rd_last, w_rd_last_d;
  logic              r_busy, r_frame_ready;
  logic              w_we;

  always_comb begin
    w_state_d    = r_state;
    w_wptr_d     = r_wptr;
    w_rptr_d     = r_rptr;
    w_len_d      = r_len;
    w_rd_cnt_d   = r_rd_cnt;
    w_dly_d      = r_dly;
    w_wrapped_d  = r_wrapped;
    w_echo_d     = r_echo;
    w_ts_d       = r_ts;
    w_rd_data_d  = r_rd_data;
    w_rd_valid_d = 1'b0;
    w_rd_last_d  = 1'b0;
    w_we         = 1'b0;

    if (bus.start_pulse) begin
      w_state_d   = StArmed;
      w_wptr_d    = '0;
      w_rptr_d    = '0;
      w_len_d     = '0;
      w_rd_cnt_d  = '0;
      w_dly_d     = '0;
      w_wrapped_d = 1'b0;
      w_echo_d    = 1'b0;
      w_ts_d      = '0;
    end else if (r_state == StArmed || r_state == StPost) begin
      if (bus.stop_recording) begin
        w_state_d = StDone;
      end else begin
        w_we     = 1'b1;
        w_wptr_d = r_wptr + 1'b1;
        if (r_len == LenMax) begin
          w_wrapped_d = 1'b1;
        end else begin
          w_len_d = r_len + 1'b1;
        end
        if (r_state == StArmed) begin
          if (bus.stop_pulse) begin
            w_ts_d    = bus.abs_counter;
            w_echo_d  = 1'b1;
            w_dly_d   = bus.stop_delay;
            w_state_d = (bus.stop_delay == '0) ? StDone : StPost;
          end
        end else begin
          w_dly_d = r_dly - 1'b1;
          if (r_dly == DLY_W'(1)) w_state_d = StDone;
        end
      end
    end else if (r_state == StDone) begin
      // Leave once the final word has been presented, so frame_ready spans rd_last.
      if (r_len == '0 || r_rd_last) begin
        w_state_d = StIdle;
      end else if (bus.rd_req && r_rd_cnt != r_len) begin
        w_rd_data_d  = r_mem[r_rptr];
        w_rd_valid_d = 1'b1;
        w_rd_last_d  = (r_rd_cnt + 1'b1 == r_len);
        w_rptr_d     = r_rptr + 1'b1;
        w_rd_cnt_d   = r_rd_cnt + 1'b1;
      end
    end

    // Entering DONE: point at the oldest surviving word.
    if (w_state_d == StDone && r_state != StDone) begin
      w_rptr_d   = w_wptr_d - w_len_d[ADDR_W-1:0];
      w_rd_cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= StIdle;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_len         <= '0;
      r_rd_cnt      <= '0;
      r_dly         <= '0;
      r_wrapped     <= 1'b0;
      r_echo        <= 1'b0;
      r_ts          <= '0;
      r_rd_data     <= '0;
      r_rd_valid    <= 1'b0;
      r_rd_last     <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_ready <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_wptr        <= w_wptr_d;
      r_rptr        <= w_rptr_d;
      r_len         <= w_len_d;
      r_rd_cnt      <= w_rd_cnt_d;
      r_dly         <= w_dly_d;
      r_wrapped     <= w_wrapped_d;
      r_echo        <= w_echo_d;
      r_ts          <= w_ts_d;
      r_rd_data     <= w_rd_data_d;
      r_rd_valid    <= w_rd_valid_d;
      r_rd_last     <= w_rd_last_d;
      r_busy        <= (w_state_d == StArmed) || (w_state_d == StPost);
      r_frame_ready <= (w_state_d == StDone);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_we && !i_reset) r_mem[r_wptr] <= bus.din;
  end

  assign bus.rd_data             = r_rd_data;
  assign bus.rd_valid            = r_rd_valid;
  assign bus.rd_last             = r_rd_last;
  assign bus.frame_ready         = r_frame_ready;
  assign bus.busy                = r_busy;
  assign bus.echo_pulse_detected = r_echo;
  assign bus.wrapped             = r_wrapped;
  assign bus.sample_length       = r_len;
  assign bus.timestamp           = r_ts;

endmodule

// File: tb/tb_echo_capture_channel.sv
// Directed bench for echo_capture_channel: each task drives one scenario and checks
// packed status / readout words against hand-computed values.
module tb_echo_capture_channel;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  echo_capture_channel_if #(.DATA_W(8), .ADDR_W(8), .TS_W(13), .DLY_W(8)) bus ();

  echo_capture_channel #(.DATA_W(8), .ADDR_W(8), .TS_W(13), .DLY_W(8)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  // {frame_ready, busy, echo, wrapped, sample_length[8:0], timestamp[12:0]}
  wire [25:0] w_status = {bus.frame_ready, bus.busy, bus.echo_pulse_detected, bus.wrapped,
                          bus.sample_length, bus.timestamp};
  // {frame_ready, rd_valid, rd_last, rd_data[7:0]}
  wire [10:0] w_rdport = {bus.frame_ready, bus.rd_valid, bus.rd_last, bus.rd_data};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.din = '0; bus.start_pulse = 0; bus.stop_pulse = 0; bus.stop_recording = 0;
    bus.stop_delay = '0; bus.abs_counter = '0; bus.rd_req = 0;
    reset = 1'b1;
    step(); step();
    vectors++;
    if (w_status !== 26'h0) begin
      miscompares++; $display("FAIL reset_status: got %h expected %h", w_status, 26'h0);
    end
    vectors++;
    if (w_rdport !== 11'h0) begin
      miscompares++; $display("FAIL reset_rdport: got %h expected %h", w_rdport, 11'h0);
    end
    reset = 1'b0;
    bus.rd_req = 1'b1;
    step();
    bus.rd_req = 1'b0;
    vectors++;
    if (w_rdport !== 11'h0) begin
      miscompares++; $display("FAIL idle_rdreq: got %h expected %h", w_rdport, 11'h0);
    end
  endtask

  task automatic test_echo_delay();
    bus.start_pulse = 1; bus.din = 8'hAA;
    step();
    bus.start_pulse = 0;
    vectors++;
    if (w_status !== {4'b0100, 9'd0, 13'h0}) begin
      miscompares++; $display("FAIL t1_armed: got %h expected %h", w_status, {4'b0100, 9'd0, 13'h0});
    end
    for (int k = 0; k < 10; k++) begin
      bus.din = 8'(k);
      if (k == 9) begin bus.stop_pulse = 1; bus.abs_counter = 13'h123; bus.stop_delay = 8'd3; end
      step();
    end
    bus.stop_pulse = 0;
    vectors++;
    if (w_status !== {4'b0110, 9'd10, 13'h123}) begin
      miscompares++; $display("FAIL t1_post: got %h expected %h", w_status, {4'b0110, 9'd10, 13'h123});
    end
    for (int k = 10; k < 13; k++) begin
      bus.din = 8'(k);
      step();
    end
    vectors++;
    if (w_status !== {4'b1010, 9'd13, 13'h123}) begin
      miscompares++; $display("FAIL t1_done: got %h expected %h", w_status, {4'b1010, 9'd13, 13'h123});
    end
    bus.rd_req = 1;
    for (int i = 0; i < 13; i++) begin
      step();
      if (i == 12) bus.rd_req = 0;
      vectors++;
      if (w_rdport !== {2'b11, 1'(i == 12), 8'(i)}) begin
        miscompares++;
        $display("FAIL t1_read[%0d]: got %h expected %h", i, w_rdport, {2'b11, 1'(i == 12), 8'(i)});
      end
    end
    step();
    vectors++;
    if (w_rdport[10:9] !== 2'b00) begin
      miscompares++; $display("FAIL t1_after: got %b expected 00", w_rdport[10:9]);
    end
  endtask

  task automatic test_wrap();
    bus.start_pulse = 1;
    step();
    bus.start_pulse = 0;
    for (int k = 0; k < 300; k++) begin
      bus.din = 8'(k);
      if (k == 299) begin bus.stop_pulse = 1; bus.stop_delay = 8'd0; bus.abs_counter = 13'h0AB; end
      step();
    end
    bus.stop_pulse = 0;
    vectors++;
    if (w_status !== {4'b1011, 9'd256, 13'h0AB}) begin
      miscompares++; $display("FAIL t2_done: got %h expected %h", w_status, {4'b1011, 9'd256, 13'h0AB});
    end
    bus.rd_req = 1;
    for (int i = 0; i < 256; i++) begin
      step();
      if (i == 255) bus.rd_req = 0;
      vectors++;
      if (w_rdport !== {2'b11, 1'(i == 255), 8'(44 + i)}) begin
        miscompares++;
        $display("FAIL t2_read[%0d]: got %h expected %h", i, w_rdport,
                 {2'b11, 1'(i == 255), 8'(44 + i)});
      end
    end
    step();
    vectors++;
    if (w_rdport[10:9] !== 2'b00) begin
      miscompares++; $display("FAIL t2_after: got %b expected 00", w_rdport[10:9]);
    end
  endtask

  task automatic test_abort();
    bus.start_pulse = 1;
    step();
    bus.start_pulse = 0;
    for (int k = 0; k < 5; k++) begin
      bus.din = 8'(8'h50 + k);
      step();
    end
    bus.stop_recording = 1; bus.din = 8'hEE;
    step();
    bus.stop_recording = 0;
    vectors++;
    if (w_status !== {4'b1000, 9'd5, 13'h0}) begin
      miscompares++; $display("FAIL t3_done: got %h expected %h", w_status, {4'b1000, 9'd5, 13'h0});
    end
    bus.rd_req = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 4) bus.rd_req = 0;
      vectors++;
      if (w_rdport !== {2'b11, 1'(i == 4), 8'(8'h50 + i)}) begin
        miscompares++;
        $display("FAIL t3_read[%0d]: got %h expected %h", i, w_rdport,
                 {2'b11, 1'(i == 4), 8'(8'h50 + i)});
      end
    end
    step();
    vectors++;
    if (w_rdport[10:9] !== 2'b00) begin
      miscompares++; $display("FAIL t3_after: got %b expected 00", w_rdport[10:9]);
    end
  endtask

  task automatic test_restart_mid_read();
    bus.start_pulse = 1;
    step();
    bus.start_pulse = 0;
    for (int k = 0; k < 6; k++) begin
      bus.din = 8'(8'h60 + k);
      step();
    end
    bus.stop_recording = 1;
    step();
    bus.stop_recording = 0;
    bus.rd_req = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (w_rdport !== {3'b110, 8'(8'h60 + i)}) begin
        miscompares++;
        $display("FAIL t4_read[%0d]: got %h expected %h", i, w_rdport, {3'b110, 8'(8'h60 + i)});
      end
    end
    bus.start_pulse = 1; bus.stop_pulse = 1; bus.abs_counter = 13'h1FF; bus.stop_delay = 8'd2;
    step();
    bus.start_pulse = 0; bus.stop_pulse = 0;
    vectors++;
    if (w_rdport[10:8] !== 3'b000) begin
      miscompares++; $display("FAIL t4_restart_rd: got %b expected 000", w_rdport[10:8]);
    end
    vectors++;
    if (w_status !== {4'b0100, 9'd0, 13'h0}) begin
      miscompares++; $display("FAIL t4_restart_st: got %h expected %h", w_status, {4'b0100, 9'd0, 13'h0});
    end
    step();
    bus.rd_req = 0;
    vectors++;
    if (w_rdport[10:9] !== 2'b00) begin
      miscompares++; $display("FAIL t4_no_valid: got %b expected 00", w_rdport[10:9]);
    end
  endtask

  task automatic test_post_abort();
    bus.start_pulse = 1;
    step();
    bus.start_pulse = 0;
    for (int k = 0; k < 4; k++) begin
      bus.din = 8'(8'h70 + k);
      if (k == 3) begin bus.stop_pulse = 1; bus.stop_delay = 8'd255; bus.abs_counter = 13'h456; end
      step();
    end
    bus.stop_pulse = 0;
    vectors++;
    if (w_status !== {4'b0110, 9'd4, 13'h456}) begin
      miscompares++; $display("FAIL t5_post: got %h expected %h", w_status, {4'b0110, 9'd4, 13'h456});
    end
    for (int j = 0; j < 10; j++) begin
      bus.din = 8'(8'h74 + j);
      bus.stop_pulse = (j == 3);
      bus.abs_counter = 13'h789;
      step();
    end
    bus.stop_pulse = 0;
    vectors++;
    if (w_status !== {4'b0110, 9'd14, 13'h456}) begin
      miscompares++; $display("FAIL t5_post10: got %h expected %h", w_status, {4'b0110, 9'd14, 13'h456});
    end
    bus.stop_recording = 1; bus.din = 8'hEE;
    step();
    bus.stop_recording = 0;
    vectors++;
    if (w_status !== {4'b1010, 9'd14, 13'h456}) begin
      miscompares++; $display("FAIL t5_done: got %h expected %h", w_status, {4'b1010, 9'd14, 13'h456});
    end
    bus.rd_req = 1;
    for (int i = 0; i < 14; i++) begin
      step();
      if (i == 13) bus.rd_req = 0;
      vectors++;
      if (w_rdport !== {2'b11, 1'(i == 13), 8'(8'h70 + i)}) begin
        miscompares++;
        $display("FAIL t5_read[%0d]: got %h expected %h", i, w_rdport,
                 {2'b11, 1'(i == 13), 8'(8'h70 + i)});
      end
    end
  endtask

  task automatic test_reset_in_post();
    step();
    bus.start_pulse = 1;
    step();
    bus.start_pulse = 0;
    for (int k = 0; k < 2; k++) begin
      bus.din = 8'(8'h90 + k);
      if (k == 1) begin bus.stop_pulse = 1; bus.stop_delay = 8'd5; bus.abs_counter = 13'h0AA; end
      step();
    end
    bus.stop_pulse = 0;
    bus.din = 8'h92;
    step();
    reset = 1;
    step();
    reset = 0;
    vectors++;
    if (w_status !== 26'h0) begin
      miscompares++; $display("FAIL t6_status: got %h expected %h", w_status, 26'h0);
    end
    vectors++;
    if (w_rdport !== 11'h0) begin
      miscompares++; $display("FAIL t6_rdport: got %h expected %h", w_rdport, 11'h0);
    end
    bus.rd_req = 1; bus.stop_pulse = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({w_rdport[10:9], bus.busy} !== 3'b000) begin
        miscompares++;
        $display("FAIL t6_idle[%0d]: got %b expected 000", i, {w_rdport[10:9], bus.busy});
      end
    end
    bus.rd_req = 0; bus.stop_pulse = 0;
  endtask

  task automatic test_empty_frame();
    bus.start_pulse = 1;
    step();
    bus.start_pulse = 0;
    bus.stop_recording = 1;
    step();
    bus.stop_recording = 0;
    vectors++;
    if (w_status !== {4'b1000, 9'd0, 13'h0}) begin
      miscompares++; $display("FAIL t7_done: got %h expected %h", w_status, {4'b1000, 9'd0, 13'h0});
    end
    bus.rd_req = 1;
    step();
    bus.rd_req = 0;
    vectors++;
    if (w_rdport[10:9] !== 2'b00) begin
      miscompares++; $display("FAIL t7_idle: got %b expected 00", w_rdport[10:9]);
    end
  endtask

  initial begin
    test_reset();
    test_echo_delay();
    test_wrap();
    test_abort();
    test_restart_mid_read();
    test_post_abort();
    test_reset_in_post();
    test_empty_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
